// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: default widths, reset PC and the NOP
// presented to decode whenever no real instruction is available.
package fetch_unit_pkg;
    localparam int          ADDR_LEN_DEF = 32;
    localparam int          INSN_LEN_DEF = 32;
    localparam int          FQ_DEPTH_DEF = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
endpackage

// File: rtl/fetch_queue.sv
// In-order {pc, insn} FIFO between fetch responses and decode; head readable combinationally, push
// visible the cycle after the write; flush empties it; push+pop on a full queue is legal.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [AW-1:0] push_pc_i,
    input  logic [DW-1:0] push_insn_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [AW-1:0] head_pc_o,
    output logic [DW-1:0] head_insn_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);
    logic [AW-1:0] pc_q   [DEPTH];
    logic [DW-1:0] insn_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset: entries are only observed while count_q is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            pc_q[wr_ptr_q]   <= push_pc_i;
            insn_q[wr_ptr_q] <= push_insn_i;
        end
    end

    assign head_pc_o   = pc_q[rd_ptr_q];
    assign head_insn_o = insn_q[rd_ptr_q];
    assign count_o     = count_q;
    assign empty_o     = (count_q == '0);
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: sequential PC generation, credit-limited imem requests, in-order response queue
// feeding decode (resp->decode one cycle); stall_IF holds the head, redirect flushes and restarts.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_LEN = ADDR_LEN_DEF,
    parameter int                INSN_LEN = INSN_LEN_DEF,
    parameter logic [ADDR_LEN-1:0] RESET_PC = ADDR_LEN'(RESET_PC_DEF),
    parameter int                FQ_DEPTH = FQ_DEPTH_DEF
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                stall_IF,
    input  logic                redirect_i,
    input  logic [ADDR_LEN-1:0] redirect_pc_i,
    output logic                imem_req_valid_o,
    output logic [ADDR_LEN-1:0] imem_req_addr_o,
    input  logic                imem_req_ready_i,
    input  logic                imem_resp_valid_i,
    input  logic [INSN_LEN-1:0] imem_resp_data_i,
    output logic [INSN_LEN-1:0] inst1_o,
    output logic [ADDR_LEN-1:0] pc1_o,
    output logic                valid1_o
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redir_pc, fq_pc;
    logic [INSN_LEN-1:0] fq_insn;
    logic [CW-1:0]       out_q, out_d, drop_q, drop_d, fq_count;
    logic [CW:0]         occ;
    logic                fq_empty, fq_push, fq_pop, req_fire;

    assign redir_pc         = {redirect_pc_i[ADDR_LEN-1:2], 2'b00};
    assign occ              = {1'b0, fq_count} + {1'b0, out_q};
    assign imem_req_valid_o = ~reset_i & ~redirect_i & (occ < (CW+1)'(FQ_DEPTH));
    assign imem_req_addr_o  = fetch_pc_q;
    assign req_fire         = imem_req_valid_o & imem_req_ready_i;
    assign fq_push          = imem_resp_valid_i & ~redirect_i & (drop_q == '0);
    assign valid1_o         = ~fq_empty;
    assign fq_pop           = valid1_o & ~stall_IF & ~redirect_i;
    assign inst1_o          = valid1_o ? fq_insn : INSN_LEN'(NOP_INSN);
    assign pc1_o            = valid1_o ? fq_pc : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        out_d      = out_q + CW'(req_fire) - CW'(imem_resp_valid_i);
        if (redirect_i) begin
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            // Every request still in flight after this cycle belongs to the abandoned path.
            drop_d     = out_q - CW'(imem_resp_valid_i);
        end else begin
            if (req_fire)                            fetch_pc_d = fetch_pc_q + ADDR_LEN'(4);
            if (fq_push)                             resp_pc_d  = resp_pc_q + ADDR_LEN'(4);
            if (imem_resp_valid_i && drop_q != '0)   drop_d     = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    fetch_queue #(.DEPTH(FQ_DEPTH), .AW(ADDR_LEN), .DW(INSN_LEN)) u_fq (
        .clk_i       (clk_i),
        .rst_i       (reset_i),
        .push_i      (fq_push),
        .push_pc_i   (resp_pc_q),
        .push_insn_i (imem_resp_data_i),
        .pop_i       (fq_pop),
        .flush_i     (redirect_i),
        .head_pc_o   (fq_pc),
        .head_insn_o (fq_insn),
        .count_o     (fq_count),
        .empty_o     (fq_empty)
    );

    a_credit: assert property (@(posedge clk_i) disable iff (reset_i) occ <= (CW+1)'(FQ_DEPTH));
    a_drop:   assert property (@(posedge clk_i) disable iff (reset_i) drop_q <= out_q);
    a_resp:   assert property (@(posedge clk_i) disable iff (reset_i) imem_resp_valid_i |-> out_q != '0);
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for redirect/reset corners, and a
// randomized run against an epoch-tagged memory/decode reference model.
module tb_fetch_unit;
    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        stall_IF = 1'b0, redirect_i = 1'b0, imem_req_ready_i = 1'b0;
    logic        imem_resp_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0, imem_resp_data_i = '0;
    logic        imem_req_valid_o, valid1_o;
    logic [31:0] imem_req_addr_o, inst1_o, pc1_o;

    fetch_unit dut (
        .clk_i(clk_i), .reset_i(reset_i), .stall_IF(stall_IF), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_valid_o(imem_req_valid_o),
        .imem_req_addr_o(imem_req_addr_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_resp_valid_i(imem_resp_valid_i), .imem_resp_data_i(imem_resp_data_i),
        .inst1_o(inst1_o), .pc1_o(pc1_o), .valid1_o(valid1_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] addr; int ep; int due; } mq_t;
    typedef struct { bit st; bit rd; bit e_rv; logic [31:0] e_addr; bit e_v1; logic [31:0] e_pc; } vec_t;

    int nerr = 0, nchk = 0, cyc = 0, epoch = 0, qcount = 0, last_due = -1;
    logic [31:0] exp_pc = 32'h0, exp_req = 32'h0;
    mq_t mq[$];
    logic s_rv, s_v1;
    logic [31:0] s_addr, s_pc, s_inst;
    vec_t tbl[13];
    bit found;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample, predict the rising-edge effect.
    task automatic run_cycle(input bit st, input bit rd, input bit rdir, input logic [31:0] rpc, input int lat);
        bit rv, pop;
        int due;
        mq_t h;
        stall_IF = st; imem_req_ready_i = rd; redirect_i = rdir; redirect_pc_i = rpc;
        rv = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_resp_valid_i = rv;
        imem_resp_data_i  = rv ? memf(mq[0].addr) : $urandom;
        #1;
        s_rv = imem_req_valid_o; s_addr = imem_req_addr_o;
        s_v1 = valid1_o; s_pc = pc1_o; s_inst = inst1_o;
        chk("req_valid", {31'b0, s_rv}, {31'b0, !rdir && (mq.size() + qcount < 4)});
        if (s_rv) chk("req_addr", s_addr, exp_req);
        chk("valid1", {31'b0, s_v1}, {31'b0, qcount > 0});
        if (qcount > 0) begin
            chk("pc1", s_pc, exp_pc);
            chk("inst1", s_inst, memf(exp_pc));
        end else begin
            chk("pc1_idle", s_pc, 32'h0);
            chk("inst1_idle", s_inst, 32'h13);
        end
        pop = (qcount > 0) && !st && !rdir;
        if (rv) begin
            h = mq.pop_front();
            if (!rdir && h.ep == epoch) qcount++;
        end
        if (pop) begin qcount--; exp_pc += 4; end
        if (s_rv && rd) begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            mq.push_back('{s_addr, epoch, due});
            exp_req += 4;
        end
        if (rdir) begin
            epoch++; qcount = 0;
            exp_pc = {rpc[31:2], 2'b00}; exp_req = {rpc[31:2], 2'b00};
        end
        cyc++;
        @(negedge clk_i);
    endtask

    initial begin
        tbl[0]  = '{0, 1, 1, 32'h00, 0, 32'h00};
        tbl[1]  = '{0, 1, 1, 32'h04, 0, 32'h00};
        tbl[2]  = '{0, 1, 1, 32'h08, 1, 32'h00};
        tbl[3]  = '{1, 1, 1, 32'h0C, 1, 32'h04};
        tbl[4]  = '{1, 1, 1, 32'h10, 1, 32'h04};
        tbl[5]  = '{1, 1, 0, 32'h00, 1, 32'h04};
        tbl[6]  = '{1, 1, 0, 32'h00, 1, 32'h04};
        tbl[7]  = '{0, 1, 0, 32'h00, 1, 32'h04};
        tbl[8]  = '{0, 1, 1, 32'h14, 1, 32'h08};
        tbl[9]  = '{0, 0, 1, 32'h18, 1, 32'h0C};
        tbl[10] = '{0, 1, 1, 32'h18, 1, 32'h10};
        tbl[11] = '{0, 1, 1, 32'h1C, 1, 32'h14};
        tbl[12] = '{0, 1, 1, 32'h20, 1, 32'h18};

        #2;
        chk("rst_req_valid", {31'b0, imem_req_valid_o}, 32'h0);
        chk("rst_valid1", {31'b0, valid1_o}, 32'h0);
        chk("rst_inst1", inst1_o, 32'h13);
        chk("rst_pc1", pc1_o, 32'h0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Directed fill/stall/ready table, latency 1
        for (int i = 0; i < 13; i++) begin
            run_cycle(tbl[i].st, tbl[i].rd, 1'b0, 32'h0, 1);
            chk("tbl_req_valid", {31'b0, s_rv}, {31'b0, tbl[i].e_rv});
            if (tbl[i].e_rv) chk("tbl_req_addr", s_addr, tbl[i].e_addr);
            chk("tbl_valid1", {31'b0, s_v1}, {31'b0, tbl[i].e_v1});
            if (tbl[i].e_v1) chk("tbl_pc1", s_pc, tbl[i].e_pc);
        end

        // Long stall: requests must stop once the credit is used up
        for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b1, 1'b0, 32'h0, 2);
        chk("stall_req_stopped", {31'b0, s_rv}, 32'h0);
        chk("stall_valid_held", {31'b0, s_v1}, 32'h1);
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 2);

        // Redirect with three requests in flight, latency 3
        run_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0040, 3);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq.size() == 3) found = 1;
            else run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 3);
        end
        chk("t3_three_in_flight", {31'b0, found}, 32'h1);
        run_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0103, 3);
        chk("t3_redirect_cycle_no_req", {31'b0, s_rv}, 32'h0);
        run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 3);
        chk("t3_first_req", s_addr, 32'h0000_0100);
        found = 0;
        for (int i = 0; i < 15 && !found; i++) begin
            run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 3);
            if (s_v1) found = 1;
        end
        chk("t3_first_valid_pc", s_pc, 32'h0000_0100);
        chk("t3_first_valid_inst", s_inst, memf(32'h0000_0100));

        // Redirect coincident with a response and a pop
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (qcount > 0 && mq.size() > 0 && mq[0].due <= cyc) found = 1;
            else run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1);
        end
        chk("t4_setup", {31'b0, found}, 32'h1);
        run_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1);
        run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1);
        chk("t4_queue_empty", {31'b0, s_v1}, 32'h0);
        chk("t4_req_valid", {31'b0, s_rv}, 32'h1);
        chk("t4_req_addr", s_addr, 32'h0000_0200);
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++)
            run_cycle(($urandom % 4) == 0, $urandom % 2, ($urandom % 32) == 0, $urandom,
                      $urandom_range(1, 5));

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 2);
        #2;
        reset_i = 1'b1; imem_resp_valid_i = 1'b0; redirect_i = 1'b0;
        #1;
        chk("arst_req_valid", {31'b0, imem_req_valid_o}, 32'h0);
        chk("arst_valid1", {31'b0, valid1_o}, 32'h0);
        chk("arst_inst1", inst1_o, 32'h13);
        chk("arst_pc1", pc1_o, 32'h0);
        mq.delete(); qcount = 0; epoch++; exp_pc = 32'h0; exp_req = 32'h0;
        @(negedge clk_i);
        @(negedge clk_i);
        cyc += 2; last_due = cyc;
        reset_i = 1'b0;
        run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1);
        chk("arst_restart_addr", s_addr, 32'h0);
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
